// File: rtl/grf_scan_reader.sv
// Debug/trace reader: walks the GRF through one async read port and streams
// (index, value) beats, snooping the write port so each beat is current when accepted.
module grf_scan_reader #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int SKIP_ZERO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] grf_addr,
  input  logic [DW-1:0] grf_rdata,
  input  logic          snoop_we,
  input  logic [AW-1:0] snoop_addr,
  input  logic [DW-1:0] snoop_wd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [AW:0]   FIRST = (AW+1)'((SKIP_ZERO != 0) ? 1 : 0);
  localparam logic [AW-1:0] LAST  = AW'(NREG - 1);

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;

  logic [DW-1:0] bypData;
  logic          holdHit;

  // The GRF commits on the same edge we capture, so a matching write must win over RD1.
  assign bypData = (snoop_we && ({1'b0, snoop_addr} == idx_q) && (idx_q != '0))
                   ? snoop_wd : grf_rdata;
  assign holdHit = snoop_we && (snoop_addr == addr_q) && (addr_q != '0);

  assign grf_addr  = idx_q[AW-1:0];
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign busy      = (state_q == SCAN);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          data_d  = bypData;
          addr_d  = idx_q[AW-1:0];
          valid_d = 1'b1;
          idx_d   = idx_q + (AW+1)'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          valid_d = 1'b0;
          idx_d   = FIRST;
          state_d = IDLE;
        end else if (valid_q && out_ready) begin
          if (addr_q == LAST) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            idx_d   = FIRST;
            state_d = IDLE;
          end else begin
            data_d = bypData;
            addr_d = idx_q[AW-1:0];
            idx_d  = idx_q + (AW+1)'(1);
          end
        end else if (valid_q && holdHit) begin
          // A stalled beat tracks CPU writes to its own register.
          data_d = snoop_wd;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= FIRST;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule
